// File: rtl/mem_unit_if.sv
// Load/store handshake between the memory-control FSM (master) and mem_unit (slave).
// Request side: memEN/RW/addr/wdata; response side: rdata/MFC/busy/err.
interface mem_unit_if #(
    parameter int WIDTH  = 16,
    parameter int AWIDTH = 6
);
    logic              memEN;
    logic              RW;
    logic [AWIDTH-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic [WIDTH-1:0]  rdata;
    logic              MFC;
    logic              busy;
    logic              err;

    modport master (
        output memEN, RW, addr, wdata,
        input  rdata, MFC, busy, err
    );

    modport slave (
        input  memEN, RW, addr, wdata,
        output rdata, MFC, busy, err
    );
endinterface

// File: rtl/mem_unit.sv
// Word-addressed data memory with programmable wait latency; optional MEM_ERR_EN flags out-of-range accesses.
// Latency: MFC rises LATENCY+1 edges after the accept edge; rdata is loaded on the edge before MFC.
// Backpressure: requester holds memEN until MFC; dropping memEN in WAIT aborts, in ACK returns to IDLE.
module mem_unit #(
    parameter int WIDTH   = 16,
    parameter int AWIDTH  = 6,
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic       clk,
    input  logic       rst,
    mem_unit_if.slave  bus
);
    localparam int              IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AWIDTH:0] DEPTH_W  = (AWIDTH+1)'(DEPTH);
    localparam logic [3:0]      CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              rw_q;
    logic [AWIDTH-1:0] addr_q;
    logic [WIDTH-1:0]  wdata_q;
    logic [WIDTH-1:0]  rdata_q;
    logic              mfc_q;
    logic              busy_q;

    logic [WIDTH-1:0]  mem [DEPTH];

    logic              acc_fire;
    logic              acc_rw;
    logic [AWIDTH-1:0] acc_addr;
    logic [WIDTH-1:0]  acc_wdata;
    logic              oor;
    logic [IW-1:0]     idx;
    logic              wr_en;

    // With zero latency the access happens on the accept edge, so use the live bus fields.
    always_comb begin
        acc_fire  = 1'b0;
        acc_rw    = rw_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        if (state == IDLE) begin
            acc_rw    = bus.RW;
            acc_addr  = bus.addr;
            acc_wdata = bus.wdata;
            acc_fire  = bus.memEN && (LATENCY == 0);
        end else if (state == WAIT) begin
            acc_fire  = bus.memEN && (cnt == 4'd0);
        end
    end

`ifdef MEM_ERR_EN
    always_comb begin
        oor = ({1'b0, acc_addr} >= DEPTH_W);
        idx = IW'(acc_addr);
    end
`else
    always_comb begin
        oor = 1'b0;
        idx = IW'({1'b0, acc_addr} % DEPTH_W);
    end
`endif

    assign wr_en = acc_fire && !acc_rw && !oor && rst;

    // Array is deliberately outside the reset domain: contents survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) mem[idx] <= acc_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            cnt     <= 4'd0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            mfc_q   <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            if (acc_fire) begin
                if (oor)         rdata_q <= '0;
                else if (acc_rw) rdata_q <= mem[idx];
            end
            case (state)
                IDLE: begin
                    mfc_q <= 1'b0;
                    if (bus.memEN) begin
                        rw_q    <= bus.RW;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        busy_q  <= 1'b1;
                        if (LATENCY == 0) begin
                            state <= ACK;
                        end else begin
                            state <= WAIT;
                            cnt   <= CNT_INIT;
                        end
                    end
                end
                WAIT: begin
                    if (!bus.memEN) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        state <= ACK;
                    end
                end
                ACK: begin
                    if (bus.memEN) begin
                        mfc_q <= 1'b1;
                    end else begin
                        mfc_q  <= 1'b0;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ERR_EN
    logic err_q;

    // err is captured with the access and held for the whole ACK phase.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                              err_q <= 1'b0;
        else if (acc_fire)                     err_q <= oor;
        else if (state == ACK && !bus.memEN)   err_q <= 1'b0;
    end

    assign bus.err = err_q;
`else
    assign bus.err = 1'b0;
`endif

    assign bus.rdata = rdata_q;
    assign bus.MFC   = mfc_q;
    assign bus.busy  = busy_q;
endmodule
